// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu.
// master: the requester/consumer side; slave: the ALU itself.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             neg_flag;
  logic             carry_flag;
  logic             ovf_flag;
  logic             illegal_op;

  modport master (
    output in_valid, op, operand1, operand2, out_ready,
    input  in_ready, out_valid, result,
    input  zero_flag, neg_flag, carry_flag, ovf_flag, illegal_op
  );

  modport slave (
    input  in_valid, op, operand1, operand2, out_ready,
    output in_ready, out_valid, result,
    output zero_flag, neg_flag, carry_flag, ovf_flag, illegal_op
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU with a registered result and NZCV-style flags.
// Single-cycle ops complete at the accept edge; MUL is an iterative
// shift-add taking WIDTH/MUL_RADIX_BITS cycles in BUSY.
// Optional feature macro: ALU_MUL_EN (MUL support). When undefined, opcode 8
// is treated as illegal and no BUSY state or multiplier is built.
module multicycle_alu #(
  parameter int WIDTH          = 32,
  parameter int MUL_RADIX_BITS = 1
) (
  input logic            clk,
  input logic            rst_n,
  multicycle_alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  if ((WIDTH < 8) || ((WIDTH % MUL_RADIX_BITS) != 0)) begin : g_cfg_error
    $error("multicycle_alu: WIDTH must be >= 8 and divisible by MUL_RADIX_BITS");
  end

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_MUL = 4'd8
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd1
`ifdef ALU_MUL_EN
    , BUSY = 2'd2
`endif
  } state_t;

  state_t           state, state_next;
  logic             accept;
  logic             load_alu;
  logic [WIDTH-1:0] a, b;

  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, alu_ill;
  logic [WIDTH:0]   add_full, sub_full;

  logic [WIDTH-1:0] result_q;
  logic             zero_q, neg_q, carry_q, ovf_q, ill_q;

  assign a      = bus.operand1;
  assign b      = bus.operand2;
  assign accept = bus.in_valid && (state == IDLE);

`ifdef ALU_MUL_EN
  localparam int K     = WIDTH / MUL_RADIX_BITS;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  logic             is_mul, mul_last;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [CNT_W-1:0] cnt;

  assign is_mul   = (bus.op == OP_MUL);
  assign mul_last = (state == BUSY) && (cnt == CNT_W'(K - 1));
  assign load_alu = accept && !is_mul;

  // Sum of this cycle's MUL_RADIX_BITS partial products onto the accumulator.
  always_comb begin
    acc_next = acc;
    for (int j = 0; j < MUL_RADIX_BITS; j++) begin
      if (mplier[j]) acc_next = acc_next + (mcand << j);
    end
  end

  // Multiplier operands, accumulator and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      mcand  <= mcand << MUL_RADIX_BITS;
      mplier <= mplier >> MUL_RADIX_BITS;
      acc    <= acc_next;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign load_alu = accept;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          state_next = is_mul ? BUSY : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef ALU_MUL_EN
      BUSY: if (mul_last) state_next = DONE;
`endif
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Single-cycle operations evaluated straight from the request lines.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    alu_r    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_ill  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_r = add_full[WIDTH-1:0];
        alu_c = add_full[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = sub_full[WIDTH-1:0];
        alu_c = sub_full[WIDTH];  // 1 means no borrow
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_SLT: alu_r = WIDTH'($signed(a) < $signed(b));
      OP_SLL: alu_r = a << b[SHW-1:0];
      OP_SRL: alu_r = a >> b[SHW-1:0];
`ifdef ALU_MUL_EN
      OP_MUL: alu_r = '0;  // produced by the BUSY iteration instead
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // Result and flag registers: loaded at a single-cycle accept or at the last MUL step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else if (load_alu) begin
      result_q <= alu_r;
      zero_q   <= (alu_r == '0);
      neg_q    <= alu_r[WIDTH-1];
      carry_q  <= alu_c;
      ovf_q    <= alu_v;
      ill_q    <= alu_ill;
    end
`ifdef ALU_MUL_EN
    else if (mul_last) begin
      result_q <= acc_next;
      zero_q   <= (acc_next == '0);
      neg_q    <= acc_next[WIDTH-1];
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end
`endif
  end

  assign bus.result     = result_q;
  assign bus.zero_flag  = zero_q;
  assign bus.neg_flag   = neg_q;
  assign bus.carry_flag = carry_q;
  assign bus.ovf_flag   = ovf_q;
  assign bus.illegal_op = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32, MUL_RADIX_BITS=1).
// Works with or without ALU_MUL_EN defined.
module tb_multicycle_alu;

  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN  = 1'b1;
`else
  localparam bit MUL_EN  = 1'b0;
`endif
  localparam int MUL_CYC = 32;
  localparam int TMO     = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  multicycle_alu_if #(.WIDTH(W)) bus();

  multicycle_alu #(.WIDTH(W), .MUL_RADIX_BITS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the arithmetic definition; flags = {Z,N,C,V,ILL}.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [4:0] f);
    longint sa, sb, exact;
    logic   c, v, ill;
    sa = $signed(a);
    sb = $signed(b);
    c = 1'b0; v = 1'b0; ill = 1'b0; r = '0;
    case (op)
      4'd0: begin
        r = a + b;
        c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        exact = sa + sb;
        v = exact != longint'($signed(r));
      end
      4'd1: begin
        r = a - b;
        c = (a >= b);
        exact = sa - sb;
        v = exact != longint'($signed(r));
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = a << (b % 32);
      4'd7: r = a >> (b % 32);
      4'd8: begin
        if (MUL_EN) r = 32'(64'(a) * 64'(b));
        else        ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    f = {(r == 32'd0), r[31], c, v, ill};
  endfunction

  function automatic logic [4:0] flags_now();
    return {bus.zero_flag, bus.neg_flag, bus.carry_flag, bus.ovf_flag, bus.illegal_op};
  endfunction

  // Wait for in_ready, present the request, return just after the accept edge.
  task automatic start_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!bus.in_ready && n < TMO) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " ready before request"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.operand1 = a;
    bus.operand2 = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op       = 4'($urandom);
    bus.operand1 = $urandom;
    bus.operand2 = $urandom;
  endtask

  // Count edges after accept until out_valid, then compare latency, result and flags.
  task automatic finish_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic [4:0]  ef;
    int          lat = 0;
    logic        ready_seen = 1'b0;
    model(op, a, b, er, ef);
    while (!bus.out_valid && lat < TMO) begin
      if (bus.in_ready) ready_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, lat, (op == 4'd8 && MUL_EN) ? MUL_CYC : 0);
    check({tag, " in_ready while busy"}, ready_seen, 1'b0);
    check({tag, " result"}, bus.result, er);
    check({tag, " flags"}, flags_now(), ef);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " in_ready after release"}, bus.in_ready, 1'b1);
    check({tag, " out_valid after release"}, bus.out_valid, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start_op(tag, op, a, b);
    finish_op(tag, op, a, b);
    release_result(tag);
  endtask

  initial begin
    logic [31:0] er, ra, rb;
    logic [4:0]  ef;
    logic [3:0]  rop;

    // Reset with a request asserted: it must be ignored.
    bus.in_valid  = 1'b1;
    bus.op        = 4'd0;
    bus.operand1  = 32'h1234_5678;
    bus.operand2  = 32'h1111_1111;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", bus.in_ready, 1'b1);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset result", bus.result, 32'h0);
    check("reset flags", flags_now(), 5'b00000);
    bus.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset out_valid", bus.out_valid, 1'b0);

    // Directed cases.
    run_op("add wrap",  4'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("sub ovf",   4'd1, 32'h8000_0000, 32'h0000_0001);
    run_op("sub borrow",4'd1, 32'd3,         32'd5);
    run_op("add ovf",   4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op("mul",       4'd8, 32'h0001_0003, 32'h0000_0005);
    run_op("slt",       4'd5, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("slt false", 4'd5, 32'h0000_0001, 32'hFFFF_FFFF);
    run_op("sll",       4'd6, 32'h0000_0001, 32'h0000_0024);
    run_op("srl",       4'd7, 32'h8000_0000, 32'd31);
    run_op("and",       4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run_op("or",        4'd3, 32'hF000_0000, 32'h0000_000F);
    run_op("xor",       4'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
    run_op("illegal f", 4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("op8",       4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Result held while the consumer stalls; a waiting request is not taken.
    start_op("hold", 4'd0, 32'h4000_0000, 32'h4000_0000);
    finish_op("hold", 4'd0, 32'h4000_0000, 32'h4000_0000);
    model(4'd0, 32'h4000_0000, 32'h4000_0000, er, ef);
    bus.in_valid = 1'b1;
    bus.op       = 4'd1;
    bus.operand1 = 32'd10;
    bus.operand2 = 32'd3;
    repeat (5) begin
      @(posedge clk); #1;
      check("hold out_valid", bus.out_valid, 1'b1);
      check("hold in_ready", bus.in_ready, 1'b0);
      check("hold result", bus.result, er);
      check("hold flags", flags_now(), ef);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("hold released in_ready", bus.in_ready, 1'b1);
    check("hold released out_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("pending sub out_valid", bus.out_valid, 1'b1);
    check("pending sub result", bus.result, 32'd7);
    check("pending sub flags", flags_now(), 5'b00100);
    release_result("pending sub");

    // Reset in the middle of an operation (BUSY for MUL, DONE otherwise).
    start_op("abort", 4'd8, 32'h0000_1234, 32'h0000_5678);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", bus.out_valid, 1'b0);
    check("abort in_ready", bus.in_ready, 1'b1);
    check("abort result", bus.result, 32'h0);
    check("abort flags", flags_now(), 5'b00000);
    bus.in_valid = 1'b1;
    bus.op       = 4'd0;
    repeat (2) @(posedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (MUL_CYC + 2) begin
      @(posedge clk); #1;
      check("abort no out_valid", bus.out_valid, 1'b0);
    end
    run_op("after abort", 4'd0, 32'd100, 32'd23);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 5 == 0) ra = {ra[31], 31'h7FFF_FFFF};
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
